// File: rtl/lcd_pattern_gen.sv
// rtl/lcd_pattern_gen.sv - raster timing and selectable test-pattern generator for LCD bring-up
module lcd_pattern_gen #(
    parameter int H_ACTIVE   = 800,
    parameter int H_FP       = 40,
    parameter int H_SYNC     = 128,
    parameter int H_BP       = 88,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 1,
    parameter int V_SYNC     = 3,
    parameter int V_BP       = 21,
    parameter int COLOR_BITS = 8,
    parameter bit SYNC_POL   = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [2:0]            mode,
    input  logic                  pat_en,
    output logic                  lcd_hs,
    output logic                  lcd_vs,
    output logic                  lcd_de,
    output logic [COLOR_BITS-1:0] lcd_r,
    output logic [COLOR_BITS-1:0] lcd_g,
    output logic [COLOR_BITS-1:0] lcd_b,
    output logic [11:0]           active_x,
    output logic [11:0]           active_y,
    output logic                  frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int N       = 3 * COLOR_BITS;
    localparam int BAR_W   = H_ACTIVE / 8;
    // The ramp advances by 2^COLOR_BITS / H_ACTIVE per pixel, split into
    // an integer step and a remainder that is carried in an accumulator.
    localparam int RAMP_Q  = (1 << COLOR_BITS) / H_ACTIVE;
    localparam int RAMP_R  = (1 << COLOR_BITS) % H_ACTIVE;

    localparam logic [11:0] H_ACT_C  = 12'(H_ACTIVE);
    localparam logic [11:0] V_ACT_C  = 12'(V_ACTIVE);
    localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 1);
    localparam logic [11:0] HS_BEG   = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] VS_BEG   = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] VS_END   = 12'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [N-1:0] BW_TOP  = {1'b1, {(N-1){1'b0}}};
    localparam logic [COLOR_BITS-1:0] ONES = {COLOR_BITS{1'b1}};

    logic [11:0]           h_cnt;
    logic [11:0]           v_cnt;
    logic [2:0]            mode_q;
    logic [7:0]            frame_cnt;
    logic [11:0]           ramp_lvl;
    logic [11:0]           ramp_acc;

    logic                  h_wrap;
    logic                  v_wrap;
    logic                  de_c;
    logic                  hs_c;
    logic                  vs_c;
    logic [4:0]            bw_idx;
    logic [N-1:0]          bw_vec;
    logic [2:0]            bar_idx;
    logic [2:0]            bar_rgb;
    logic [12:0]           acc_sum;
    logic [11:0]           acc_nxt;
    logic [11:0]           lvl_nxt;
    logic [12:0]           xs;
    logic                  checker_white;
    logic                  hatch_white;
    logic [COLOR_BITS-1:0] pix_r;
    logic [COLOR_BITS-1:0] pix_g;
    logic [COLOR_BITS-1:0] pix_b;
    logic                  unused_bits;

    assign h_wrap = (h_cnt == H_LAST);
    assign v_wrap = (v_cnt == V_LAST);
    assign de_c   = (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
    assign hs_c   = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
    assign vs_c   = (v_cnt >= VS_BEG) && (v_cnt < VS_END);

    // Raster counters; v_cnt steps when the line wraps
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_wrap) begin
            h_cnt <= '0;
            v_cnt <= v_wrap ? 12'd0 : v_cnt + 12'd1;
        end else begin
            h_cnt <= h_cnt + 12'd1;
        end
    end

    // Mode and frame counter update only at the frame boundary so a frame is never mixed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q    <= '0;
            frame_cnt <= '0;
        end else if (h_wrap && v_wrap) begin
            mode_q    <= mode;
            frame_cnt <= frame_cnt + 8'd1;
        end
    end

    // Next ramp step: add the fractional remainder, carry one level when it overflows
    always_comb begin
        acc_sum = {1'b0, ramp_acc} + 13'(RAMP_R);
        acc_nxt = acc_sum[11:0];
        lvl_nxt = ramp_lvl + 12'(RAMP_Q);
        if (acc_sum >= 13'(H_ACTIVE)) begin
            acc_nxt = 12'(acc_sum - 13'(H_ACTIVE));
            lvl_nxt = ramp_lvl + 12'(RAMP_Q) + 12'd1;
        end
    end

    // Ramp level tracks floor(h_cnt * 2^COLOR_BITS / H_ACTIVE), restarting every line
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ramp_lvl <= '0;
            ramp_acc <= '0;
        end else if (h_wrap) begin
            ramp_lvl <= '0;
            ramp_acc <= '0;
        end else if (h_cnt < H_ACT_C) begin
            ramp_lvl <= lvl_nxt;
            ramp_acc <= acc_nxt;
        end
    end

    // Bar indices from elaboration-time boundary constants
    always_comb begin
        bw_idx  = '0;
        bar_idx = '0;
        for (int i = 1; i < N; i++) begin
            if (h_cnt >= 12'((i * H_ACTIVE) / N)) bw_idx = 5'(i);
        end
        for (int k = 1; k < 8; k++) begin
            if (h_cnt >= 12'(k * BAR_W)) bar_idx = 3'(k);
        end
    end

    // Colour-bar order: white, yellow, cyan, green, magenta, red, blue, black
    always_comb begin
        bar_rgb = 3'b000;
        case (bar_idx)
            3'd0:    bar_rgb = 3'b111;
            3'd1:    bar_rgb = 3'b110;
            3'd2:    bar_rgb = 3'b011;
            3'd3:    bar_rgb = 3'b010;
            3'd4:    bar_rgb = 3'b101;
            3'd5:    bar_rgb = 3'b100;
            3'd6:    bar_rgb = 3'b001;
            default: bar_rgb = 3'b000;
        endcase
    end

    assign bw_vec        = BW_TOP >> bw_idx;
    assign xs            = 13'(h_cnt) + 13'(frame_cnt);
    assign checker_white = xs[5] ^ v_cnt[5];
    assign hatch_white   = (h_cnt[5:0] == 6'd0) || (v_cnt[5:0] == 6'd0) ||
                           (h_cnt == H_ACT_C - 12'd1) || (v_cnt == V_ACT_C - 12'd1);
    assign unused_bits   = ^{xs[12:6], xs[4:0], ramp_lvl[11:COLOR_BITS]};

    // Pattern selection for the pixel addressed by the current counters
    always_comb begin
        pix_r = '0;
        pix_g = '0;
        pix_b = '0;
        case (mode_q)
            3'd0: {pix_r, pix_g, pix_b} = bw_vec;
            3'd1: begin
                pix_r = bar_rgb[2] ? ONES : '0;
                pix_g = bar_rgb[1] ? ONES : '0;
                pix_b = bar_rgb[0] ? ONES : '0;
            end
            3'd2: begin
                pix_r = ramp_lvl[COLOR_BITS-1:0];
                pix_g = ramp_lvl[COLOR_BITS-1:0];
                pix_b = ramp_lvl[COLOR_BITS-1:0];
            end
            3'd3: begin
                pix_r = checker_white ? ONES : '0;
                pix_g = checker_white ? ONES : '0;
                pix_b = checker_white ? ONES : '0;
            end
            3'd4: begin
                pix_r = hatch_white ? ONES : '0;
                pix_g = hatch_white ? ONES : '0;
                pix_b = hatch_white ? ONES : '0;
            end
            default: begin
                pix_r = '0;
                pix_g = '0;
                pix_b = '0;
            end
        endcase
    end

    // Output register: every pin is one clock behind the counter state that produced it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lcd_hs      <= ~SYNC_POL;
            lcd_vs      <= ~SYNC_POL;
            lcd_de      <= 1'b0;
            lcd_r       <= '0;
            lcd_g       <= '0;
            lcd_b       <= '0;
            active_x    <= '0;
            active_y    <= '0;
            frame_start <= 1'b0;
        end else begin
            lcd_hs      <= hs_c ? SYNC_POL : ~SYNC_POL;
            lcd_vs      <= vs_c ? SYNC_POL : ~SYNC_POL;
            lcd_de      <= de_c;
            lcd_r       <= (de_c && pat_en) ? pix_r : '0;
            lcd_g       <= (de_c && pat_en) ? pix_g : '0;
            lcd_b       <= (de_c && pat_en) ? pix_b : '0;
            active_x    <= de_c ? h_cnt : 12'd0;
            active_y    <= de_c ? v_cnt : 12'd0;
            frame_start <= (h_cnt == 12'd0) && (v_cnt == 12'd0);
        end
    end

endmodule

// File: tb/tb_lcd_pattern_gen.sv
// tb/tb_lcd_pattern_gen.sv - scoreboard bench for lcd_pattern_gen (two parameter sets)
module tb_lcd_pattern_gen;

    typedef struct {
        int          frame;
        int          x;
        int          y;
        logic [29:0] rgb;
        string       name;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   fa = -1;
    int   fb = -1;
    int   blank_bad = 0;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] mode_a = 3'd0;
    logic [2:0] mode_b = 3'd2;
    logic       pat_en_a = 1'b1;
    logic       pat_en_b = 1'b1;

    logic        hs_a, vs_a, de_a, fs_a;
    logic [7:0]  r_a, g_a, b_a;
    logic [11:0] ax_a, ay_a;
    logic        hs_b, vs_b, de_b, fs_b;
    logic [5:0]  r_b, g_b, b_b;
    logic [11:0] ax_b, ay_b;

    lcd_pattern_gen #(
        .H_ACTIVE(800), .H_FP(40), .H_SYNC(128), .H_BP(88),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .COLOR_BITS(8), .SYNC_POL(1'b0)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .mode(mode_a), .pat_en(pat_en_a),
        .lcd_hs(hs_a), .lcd_vs(vs_a), .lcd_de(de_a),
        .lcd_r(r_a), .lcd_g(g_a), .lcd_b(b_a),
        .active_x(ax_a), .active_y(ay_a), .frame_start(fs_a)
    );

    lcd_pattern_gen #(
        .H_ACTIVE(480), .H_FP(8), .H_SYNC(16), .H_BP(8),
        .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .COLOR_BITS(6), .SYNC_POL(1'b1)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .mode(mode_b), .pat_en(pat_en_b),
        .lcd_hs(hs_b), .lcd_vs(vs_b), .lcd_de(de_b),
        .lcd_r(r_b), .lcd_g(g_b), .lcd_b(b_b),
        .active_x(ax_b), .active_y(ay_b), .frame_start(fs_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input longint act, input longint req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
        end
    endtask

    function automatic void pa(input int f, input int x, input int y, input logic [29:0] v, input string nm);
        qa.push_back('{f, x, y, v, nm});
    endfunction

    function automatic void pb(input int f, input int x, input int y, input logic [29:0] v, input string nm);
        qb.push_back('{f, x, y, v, nm});
    endfunction

    task automatic wait_pix(input bit sel, input int f, input int x, input int y);
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (!sel && fa == f && de_a && int'(ax_a) == x && int'(ay_a) == y) break;
            if (sel && fb == f && de_b && int'(ax_b) == x && int'(ay_b) == y) break;
            n++;
            if (n > 20000) begin
                n_cmp++;
                n_bad++;
                $display("FAIL wait_pix: dut %0d pixel (%0d,%0d) of frame %0d not reached, expected it within 20000 cycles", sel, x, y, f);
                break;
            end
        end
    endtask

    // Scoreboard monitor, DUT A: frame index from frame_start, compare when the queued pixel is shown
    always @(negedge clk) begin
        if (rst_n) begin
            if (fs_a) fa++;
            if (qa.size() > 0) begin
                if (fa > qa[0].frame || (fa == qa[0].frame && de_a &&
                    (int'(ay_a) > qa[0].y || (int'(ay_a) == qa[0].y && int'(ax_a) > qa[0].x)))) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL %s: pixel passed unobserved, expected 0x%0h", qa[0].name, qa[0].rgb);
                    void'(qa.pop_front());
                end else if (fa == qa[0].frame && de_a && int'(ax_a) == qa[0].x && int'(ay_a) == qa[0].y) begin
                    chk(qa[0].name, longint'({r_a, g_a, b_a}), longint'(qa[0].rgb));
                    void'(qa.pop_front());
                end
            end
        end
    end

    // Scoreboard monitor, DUT B
    always @(negedge clk) begin
        if (rst_n) begin
            if (fs_b) fb++;
            if (qb.size() > 0) begin
                if (fb > qb[0].frame || (fb == qb[0].frame && de_b &&
                    (int'(ay_b) > qb[0].y || (int'(ay_b) == qb[0].y && int'(ax_b) > qb[0].x)))) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL %s: pixel passed unobserved, expected 0x%0h", qb[0].name, qb[0].rgb);
                    void'(qb.pop_front());
                end else if (fb == qb[0].frame && de_b && int'(ax_b) == qb[0].x && int'(ay_b) == qb[0].y) begin
                    chk(qb[0].name, longint'({r_b, g_b, b_b}), longint'(qb[0].rgb));
                    void'(qb.pop_front());
                end
            end
        end
    end

    int   de_run_a, hs_run_a, vs_run_a, t_de_a, t_hs_a, t_fs_a;
    logic de_q_a, hs_q_a, vs_q_a;

    // Timing monitor, DUT A (H_TOTAL 1056, V_TOTAL 7, active-low syncs)
    always @(negedge clk) begin
        if (!rst_n) begin
            de_run_a = 0; hs_run_a = 0; vs_run_a = 0;
            t_de_a = -1; t_hs_a = -1; t_fs_a = -1;
            de_q_a = 1'b0; hs_q_a = 1'b1; vs_q_a = 1'b1;
        end else begin
            if (!de_a && ({r_a, g_a, b_a} != 24'h0 || ax_a != 12'h0 || ay_a != 12'h0)) blank_bad++;
            if (de_a) de_run_a++;
            else if (de_run_a != 0) begin
                chk("de_len", de_run_a, 800);
                de_run_a = 0;
            end
            if (de_a && !de_q_a) t_de_a = cyc;
            if (!hs_a) hs_run_a++;
            if (!hs_a && hs_q_a) begin
                if (t_de_a >= 0 && cyc - t_de_a < 1056) chk("hs_offset", cyc - t_de_a, 840);
                if (t_hs_a >= 0) chk("line_period", cyc - t_hs_a, 1056);
                t_hs_a = cyc;
            end
            if (hs_a && !hs_q_a) begin
                chk("hs_len", hs_run_a, 128);
                hs_run_a = 0;
            end
            if (!vs_a) vs_run_a++;
            if (!vs_a && vs_q_a && t_fs_a >= 0) chk("vs_offset", cyc - t_fs_a, 4 * 1056);
            if (vs_a && !vs_q_a) begin
                chk("vs_len", vs_run_a, 2 * 1056);
                vs_run_a = 0;
            end
            if (fs_a) begin
                if (t_fs_a >= 0) chk("frame_period", cyc - t_fs_a, 1056 * 7);
                t_fs_a = cyc;
            end
            de_q_a = de_a; hs_q_a = hs_a; vs_q_a = vs_a;
        end
    end

    int   hs_run_b, vs_run_b;
    logic hs_q_b, vs_q_b;

    // Timing monitor, DUT B (active-high syncs)
    always @(negedge clk) begin
        if (!rst_n) begin
            hs_run_b = 0; vs_run_b = 0; hs_q_b = 1'b0; vs_q_b = 1'b0;
        end else begin
            if (hs_b) hs_run_b++;
            if (!hs_b && hs_q_b) begin
                chk("b_hs_len", hs_run_b, 16);
                hs_run_b = 0;
            end
            if (vs_b) vs_run_b++;
            if (!vs_b && vs_q_b) begin
                chk("b_vs_len", vs_run_b, 512);
                vs_run_b = 0;
            end
            hs_q_b = hs_b; vs_q_b = vs_b;
        end
    end

    // DUT B stimulus: mode 2 becomes active in frame 1, one-pixel pat_en drop on line 1
    initial begin
        pb(0,   0, 0, 30'h20000, "b_bw_x0");
        pb(0, 479, 0, 30'h00001, "b_bw_x479");
        pb(1,   0, 0, 30'h00000, "b_ramp_x0");
        pb(1,   7, 0, 30'h00000, "b_ramp_x7");
        pb(1,   8, 0, 30'h01041, "b_ramp_x8");
        pb(1, 240, 0, 30'h20820, "b_ramp_x240");
        pb(1, 479, 0, 30'h3FFFF, "b_ramp_x479");
        pb(1, 299, 1, 30'h279E7, "b_ramp_x299");
        pb(1, 300, 1, 30'h00000, "b_paten_off_x300");
        pb(1, 301, 1, 30'h28A28, "b_ramp_x301");
        wait_pix(1'b1, 1, 299, 1);
        pat_en_b = 1'b0;
        @(negedge clk);
        pat_en_b = 1'b1;
    end

    // DUT A stimulus and run control
    initial begin
        pa(0,   0, 0, 30'h800000, "bw_x0");
        pa(0,  32, 0, 30'h800000, "bw_x32");
        pa(0,  33, 0, 30'h400000, "bw_x33");
        pa(0, 265, 0, 30'h010000, "bw_x265");
        pa(0, 266, 0, 30'h008000, "bw_x266");
        pa(0, 799, 0, 30'h000001, "bw_x799");
        pa(0,   0, 2, 30'h800000, "m0_hold_x0");
        pa(0, 799, 2, 30'h000001, "m0_hold_x799");
        pa(1,   0, 0, 30'hFFFFFF, "cb_x0");
        pa(1,  99, 0, 30'hFFFFFF, "cb_x99");
        pa(1, 100, 0, 30'hFFFF00, "cb_x100");
        pa(1, 300, 0, 30'h00FF00, "cb_x300");
        pa(1, 699, 0, 30'h0000FF, "cb_x699");
        pa(1, 799, 0, 30'h000000, "cb_x799");
        pa(2,  29, 0, 30'h000000, "chk_f2_x29");
        pa(2,  30, 0, 30'hFFFFFF, "chk_f2_x30");
        pa(3,  28, 0, 30'h000000, "chk_f3_x28");
        pa(3,  29, 0, 30'hFFFFFF, "chk_f3_x29");
        pa(4,   0, 1, 30'hFFFFFF, "xh_x0");
        pa(4,   1, 1, 30'h000000, "xh_x1");
        pa(4,  63, 1, 30'h000000, "xh_x63");
        pa(4,  64, 1, 30'hFFFFFF, "xh_x64");
        pa(4, 799, 1, 30'hFFFFFF, "xh_xlast");
        pa(4,   5, 2, 30'hFFFFFF, "xh_ylast");
        pa(5,   0, 0, 30'hFFFFFF, "cb_f5_x0");
        pa(6,   0, 0, 30'h800000, "rst_m0_x0");
        pa(6,  33, 0, 30'h400000, "rst_m0_x33");
        pa(7,   0, 0, 30'h000000, "m5_x0");
        pa(7, 799, 1, 30'h000000, "m5_x799");

        repeat (3) @(negedge clk);
        chk("rst_de", de_a, 0);
        chk("rst_hs", hs_a, 1);
        chk("rst_vs", vs_a, 1);
        chk("rst_rgb", longint'({r_a, g_a, b_a}), 0);
        chk("rst_xy", longint'({ax_a, ay_a}), 0);
        chk("rst_fs", fs_a, 0);
        chk("rst_hs_b", hs_b, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("first_de", de_a, 1);
        chk("first_fs", fs_a, 1);

        wait_pix(1'b0, 0, 400, 1); mode_a = 3'd1;
        wait_pix(1'b0, 1, 400, 1); mode_a = 3'd3;
        wait_pix(1'b0, 3, 400, 1); mode_a = 3'd4;
        wait_pix(1'b0, 4, 400, 2); mode_a = 3'd1;
        wait_pix(1'b0, 5,  10, 0); mode_a = 3'd5;
        wait_pix(1'b0, 5, 399, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_de", de_a, 0);
        chk("async_hs", hs_a, 1);
        chk("async_vs", vs_a, 1);
        chk("async_rgb", longint'({r_a, g_a, b_a}), 0);
        chk("async_xy", longint'({ax_a, ay_a}), 0);
        chk("async_fs", fs_a, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rerun_de", de_a, 1);
        chk("rerun_fs", fs_a, 1);

        for (int i = 0; i < 30000 && (qa.size() > 0 || qb.size() > 0); i++) @(negedge clk);
        while (qa.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: never observed, expected 0x%0h", qa[0].name, qa[0].rgb);
            void'(qa.pop_front());
        end
        while (qb.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: never observed, expected 0x%0h", qb[0].name, qb[0].rgb);
            void'(qb.pop_front());
        end
        chk("blank_outputs", blank_bad, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
